// File: rtl/ring_seq_checker.sv
// Ring counter sequence checker.
// Samples a one-hot ring word whenever ring_valid is high, decodes it to a binary index,
// flags non-one-hot samples and out-of-order rotations, and reports lock once LOCK_CNT
// consecutive in-order legal samples have been seen.
// Optional saturating error counter: define RING_SEQ_CHECKER_ERRCNT_EN to add err_count.
module ring_seq_checker #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned IDX_W    = $clog2(WIDTH),
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             ring_valid,
  output logic [IDX_W-1:0] index,
  output logic             index_valid,
  output logic             locked,
  output logic             onehot_err,
`ifdef RING_SEQ_CHECKER_ERRCNT_EN
  output logic             seq_err,
  output logic [CNT_W-1:0] err_count
`else
  output logic             seq_err
`endif
);

  // Reject unsupported configurations at elaboration time.
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("ring_seq_checker: WIDTH must be 2..16");
  end
  if (LOCK_CNT < 1 || LOCK_CNT > 15) begin : g_bad_lock
    $error("ring_seq_checker: LOCK_CNT must be 1..15");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("ring_seq_checker: CNT_W must be at least 1");
  end

  localparam int unsigned OnesW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StHunt,
    StTrack,
    StLocked
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [3:0]       match_cnt;

  logic [OnesW-1:0] ones;
  logic [IDX_W-1:0] dec_idx;
  logic             legal;
  logic [WIDTH-1:0] expected;
  logic             in_order;
  logic             lock_hit;

  // Population count and bit-position decode of the incoming sample.
  always_comb begin
    ones    = '0;
    dec_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) begin
        ones    = ones + OnesW'(1);
        dec_idx = IDX_W'(i);
      end
    end
  end

  assign legal    = (ones == OnesW'(1));
  // Next in-order value is prev rotated left by one, MSB wrapping to bit 0.
  assign expected = {prev[WIDTH-2:0], prev[WIDTH-1]};
  assign in_order = (ring_in == expected);
  // match_cnt stays below LOCK_CNT while tracking, so the 4-bit increment cannot wrap.
  assign lock_hit = ((match_cnt + 4'd1) >= 4'(LOCK_CNT));

  // Lock FSM with registered index, lock flag and error pulses.
  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= StHunt;
      prev        <= '0;
      match_cnt   <= '0;
      index       <= '0;
      index_valid <= 1'b0;
      locked      <= 1'b0;
      onehot_err  <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      index_valid <= 1'b0;
      onehot_err  <= 1'b0;
      seq_err     <= 1'b0;
      if (ring_valid) begin
        if (!legal) begin
          // Any illegal sample drops back to hunting; index and prev hold.
          onehot_err <= 1'b1;
          state      <= StHunt;
          locked     <= 1'b0;
        end else begin
          index       <= dec_idx;
          index_valid <= 1'b1;
          prev        <= ring_in;
          unique case (state)
            StHunt: begin
              match_cnt <= 4'd1;
              if (LOCK_CNT == 1) begin
                state  <= StLocked;
                locked <= 1'b1;
              end else begin
                state  <= StTrack;
                locked <= 1'b0;
              end
            end
            StTrack: begin
              if (in_order) begin
                match_cnt <= match_cnt + 4'd1;
                if (lock_hit) begin
                  state  <= StLocked;
                  locked <= 1'b1;
                end
              end else begin
                // Reseed on the new value without flagging an error.
                match_cnt <= 4'd1;
              end
            end
            StLocked: begin
              if (!in_order) begin
                seq_err   <= 1'b1;
                match_cnt <= 4'd1;
                state     <= StTrack;
                locked    <= 1'b0;
              end
            end
            default: begin
              state  <= StHunt;
              locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

`ifdef RING_SEQ_CHECKER_ERRCNT_EN
  logic err_event;

  // Same conditions that raise onehot_err or seq_err on the next edge.
  assign err_event = ring_valid && (!legal || ((state == StLocked) && !in_order));

  // Saturating error counter, cleared only by clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      err_count <= '0;
    end else if (err_event && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ring_seq_checker.sv
// Directed self-checking bench for ring_seq_checker (WIDTH=4, LOCK_CNT=3).
// With RING_SEQ_CHECKER_ERRCNT_EN defined, err_count is also checked with CNT_W=2.
module tb_ring_seq_checker;

  localparam int unsigned CntW = 2;

  logic       clk;
  logic       clear;
  logic [3:0] ring_in;
  logic       ring_valid;
  logic [1:0] index;
  logic       index_valid;
  logic       locked;
  logic       onehot_err;
  logic       seq_err;
`ifdef RING_SEQ_CHECKER_ERRCNT_EN
  logic [CntW-1:0] err_count;
`endif

  int checks;
  int errors;

  ring_seq_checker #(
    .WIDTH   (4),
    .IDX_W   (2),
    .LOCK_CNT(3),
    .CNT_W   (CntW)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .ring_in    (ring_in),
    .ring_valid (ring_valid),
    .index      (index),
    .index_valid(index_valid),
    .locked     (locked),
    .onehot_err (onehot_err),
`ifdef RING_SEQ_CHECKER_ERRCNT_EN
    .seq_err    (seq_err),
    .err_count  (err_count)
`else
    .seq_err    (seq_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic step(input logic [3:0] r, input logic v, input logic c);
    ring_in    = r;
    ring_valid = v;
    clear      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int idx, input bit iv, input bit lk,
                            input bit oe, input bit se, input int ec);
    check_eq({tag, ".index"}, 32'(index), 32'(idx));
    check_eq({tag, ".index_valid"}, 32'(index_valid), 32'(iv));
    check_eq({tag, ".locked"}, 32'(locked), 32'(lk));
    check_eq({tag, ".onehot_err"}, 32'(onehot_err), 32'(oe));
    check_eq({tag, ".seq_err"}, 32'(seq_err), 32'(se));
`ifdef RING_SEQ_CHECKER_ERRCNT_EN
    check_eq({tag, ".err_count"}, 32'(err_count), 32'(ec));
`endif
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    checks     = 0;
    errors     = 0;
    clear      = 1'b1;
    ring_in    = 4'b0000;
    ring_valid = 1'b0;
    #1;

    // Clear dominates a valid sample.
    step(4'b0001, 1'b1, 1'b1);
    step(4'b0001, 1'b1, 1'b1);
    expect_out("rst", 0, 0, 0, 0, 0, 0);

    // Clean sequence, lock after third sample, wrap is in order.
    step(4'b0001, 1'b1, 1'b0); expect_out("s0", 0, 1, 0, 0, 0, 0);
    step(4'b0010, 1'b1, 1'b0); expect_out("s1", 1, 1, 0, 0, 0, 0);
    step(4'b0100, 1'b1, 1'b0); expect_out("s2", 2, 1, 1, 0, 0, 0);
    step(4'b1000, 1'b1, 1'b0); expect_out("s3", 3, 1, 1, 0, 0, 0);
    step(4'b0001, 1'b1, 1'b0); expect_out("wrap", 0, 1, 1, 0, 0, 0);

    // Multi-hot while locked.
    step(4'b0110, 1'b1, 1'b0); expect_out("multihot", 0, 0, 0, 1, 0, 1);
    step(4'b0001, 1'b1, 1'b0); expect_out("re0", 0, 1, 0, 0, 0, 1);
    step(4'b0010, 1'b1, 1'b0); expect_out("re1", 1, 1, 0, 0, 0, 1);
    step(4'b0100, 1'b1, 1'b0); expect_out("re2", 2, 1, 1, 0, 0, 1);
    step(4'b1000, 1'b1, 1'b0); expect_out("re3", 3, 1, 1, 0, 0, 1);
    step(4'b0001, 1'b1, 1'b0); expect_out("re4", 0, 1, 1, 0, 0, 1);
    step(4'b0010, 1'b1, 1'b0); expect_out("re5", 1, 1, 1, 0, 0, 1);

    // Skip from 0010 to 1000 while locked.
    step(4'b1000, 1'b1, 1'b0); expect_out("skip", 3, 1, 0, 0, 1, 2);
    step(4'b0001, 1'b1, 1'b0); expect_out("sk1", 0, 1, 0, 0, 0, 2);
    step(4'b0010, 1'b1, 1'b0); expect_out("sk2", 1, 1, 1, 0, 0, 2);
    step(4'b0100, 1'b1, 1'b0); expect_out("sk3", 2, 1, 1, 0, 0, 2);

    // Counter held in reset: one seq_err, then silent reseeding.
    step(4'b0001, 1'b1, 1'b0); expect_out("stall0", 0, 1, 0, 0, 1, 3);
    for (int k = 0; k < 3; k++) begin
      step(4'b0001, 1'b1, 1'b0); expect_out("stallN", 0, 1, 0, 0, 0, 3);
    end

    // Invalid cycles are ignored, even with garbage on ring_in.
    step(4'b0001, 1'b0, 1'b1); expect_out("clr", 0, 0, 0, 0, 0, 0);
    step(4'b0001, 1'b1, 1'b0); expect_out("v0", 0, 1, 0, 0, 0, 0);
    step(4'b1111, 1'b0, 1'b0); expect_out("gap0", 0, 0, 0, 0, 0, 0);
    step(4'b0010, 1'b1, 1'b0); expect_out("v1", 1, 1, 0, 0, 0, 0);
    step(4'b1111, 1'b0, 1'b0); expect_out("gap1", 1, 0, 0, 0, 0, 0);
    step(4'b0100, 1'b1, 1'b0); expect_out("v2", 2, 1, 1, 0, 0, 0);
    step(4'b0000, 1'b1, 1'b0); expect_out("zero", 2, 0, 0, 1, 0, 1);

    // Relock, then clear alongside an illegal sample.
    step(4'b0001, 1'b1, 1'b0); expect_out("l0", 0, 1, 0, 0, 0, 1);
    step(4'b0010, 1'b1, 1'b0); expect_out("l1", 1, 1, 0, 0, 0, 1);
    step(4'b0100, 1'b1, 1'b0); expect_out("l2", 2, 1, 1, 0, 0, 1);
    step(4'b0110, 1'b1, 1'b1); expect_out("clrlock", 0, 0, 0, 0, 0, 0);

    // Repeated illegal samples saturate the error counter.
    for (int k = 0; k < 5; k++) begin
      step(4'b1100, 1'b1, 1'b0); expect_out("illegal", 0, 0, 0, 1, 0, sat_exp[k]);
    end
    step(4'b1100, 1'b1, 1'b1); expect_out("clrill", 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
